inp_bcd2bin: RTL and testbench

Sequential BCD-to-binary converter for the processor's input path; the inverse of the output binary-to-BCD display converter. It captures NDIG packed BCD digits (thousands, hundreds, tens, units from the switch/keypad front end) on a start request. It converts them by reverse double-dabble, one bit per clock, and presents a zero-extended binary operand to the ALU/register-file input mux with a one-cycle valid pulse. Invalid digits (>9) are flagged instead of converted.

---
 rtl/inp_bcd2bin_pkg.sv | 19 +
 rtl/inp_bcd2bin_digit_adj.sv | 16 +
 rtl/inp_bcd2bin.sv | 147 ++++++++++++++
 tb/tb_inp_bcd2bin.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/inp_bcd2bin_pkg.sv
// Shared definitions for the input-path BCD-to-binary converter.
// Holds the FSM state encoding, the BCD digit constants used by the
// reverse double-dabble adjust cell, and the default geometry.
package inp_bcd2bin_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] BCD_ADJ_TH = 4'd8;
    localparam logic [3:0] BCD_ADJ    = 4'd3;

    localparam int NDIG_DEF  = 4;
    localparam int OUT_W_DEF = 32;

endpackage

// File: rtl/inp_bcd2bin_digit_adj.sv
// Reverse double-dabble correction for one BCD digit: after a right shift a
// digit that reads 8 or more carried a half-ten down from the digit above,
// so 3 is taken off to bring it back to a legal BCD weight.
// Ports:
//   digit_i  4-bit digit after the shift
//   digit_o  corrected digit
module inp_bcd2bin_digit_adj
    import inp_bcd2bin_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= BCD_ADJ_TH) ? (digit_i - BCD_ADJ) : digit_i;

endmodule

// File: rtl/inp_bcd2bin.sv
// Sequential BCD-to-binary converter for the processor input path.
// Captures NDIG packed BCD digits on start, converts them one bit per clock
// by reverse double-dabble and presents a zero-extended binary value with a
// one-cycle valid pulse. Any digit above 9 is reported through err instead.
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   start    conversion request, accepted only when idle and not busy
//   bcd_in   packed digits, [3:0] = units
//   bin_out  converted value, held until the next result
//   valid    one-cycle pulse, bin_out/err are new this cycle
//   busy     request in progress
//   err      illegal digit seen in the captured request
//
// state | meaning
// IDLE  | waiting for start (also the one cooldown cycle after a result)
// CONV  | shifting one bit per edge, 4*NDIG iterations
// DONE  | result is registered onto the outputs at the next edge
module inp_bcd2bin
    import inp_bcd2bin_pkg::*;
#(
    parameter int NDIG  = NDIG_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*NDIG-1:0]   bcd_in,
    output logic [OUT_W-1:0]    bin_out,
    output logic                valid,
    output logic                busy,
    output logic                err
);

    localparam int BW = 4 * NDIG;
    localparam int CW = $clog2(BW + 1);

    state_e           state_q,   state_d;
    logic [BW-1:0]    bcd_q,     bcd_d;
    logic [BW-1:0]    bin_q,     bin_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic             bad_q,     bad_d;
    logic [OUT_W-1:0] bin_out_q, bin_out_d;
    logic             valid_q,   valid_d;
    logic             err_q,     err_d;
    logic             busy_q,    busy_d;

    logic [BW-1:0]    bcd_shr;
    logic [BW-1:0]    bcd_adj;
    logic             in_bad;

    assign bcd_shr = bcd_q >> 1;

    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        inp_bcd2bin_digit_adj u_adj (
            .digit_i (bcd_shr[4*g +: 4]),
            .digit_o (bcd_adj[4*g +: 4])
        );
    end

    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_in[4*i +: 4] > BCD_MAX) begin
                in_bad = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        cnt_d     = cnt_q;
        bad_d     = bad_q;
        bin_out_d = bin_out_q;
        err_d     = err_q;
        valid_d   = 1'b0;
        busy_d    = busy_q;

        // busy stays up through the valid cycle, which also keeps the FSM
        // from accepting a new request until one full idle cycle has passed
        if (valid_q) begin
            busy_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !busy_q) begin
                    bcd_d   = bcd_in;
                    bin_d   = '0;
                    cnt_d   = '0;
                    bad_d   = in_bad;
                    busy_d  = 1'b1;
                    state_d = in_bad ? ST_DONE : ST_CONV;
                end
            end
            ST_CONV: begin
                bin_d   = {bcd_q[0], bin_q[BW-1:1]};
                bcd_d   = bcd_adj;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(BW - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bin_out_d = bad_q ? '0 : OUT_W'(bin_q);
                err_d     = bad_q;
                valid_d   = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bcd_q     <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            bad_q     <= 1'b0;
            bin_out_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            cnt_q     <= cnt_d;
            bad_q     <= bad_d;
            bin_out_q <= bin_out_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign bin_out = bin_out_q;
    assign valid   = valid_q;
    assign busy    = busy_q;
    assign err     = err_q;

endmodule

// File: tb/tb_inp_bcd2bin.sv
module tb_inp_bcd2bin;

    localparam int NDIG  = 4;
    localparam int OUT_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [4*NDIG-1:0] bcd_in;
    logic [OUT_W-1:0]  bin_out;
    logic              valid;
    logic              busy;
    logic              err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    inp_bcd2bin #(.NDIG(NDIG), .OUT_W(OUT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .bin_out (bin_out),
        .valid   (valid),
        .busy    (busy),
        .err     (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Decimal value of the digits; error if any digit is not 0..9.
    function automatic void model(input logic [4*NDIG-1:0] b,
                                  output logic [31:0] v, output logic e);
        int unsigned acc;
        int unsigned d;
        acc = 0;
        e   = 1'b0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            d = 32'(b[4*i +: 4]);
            if (d > 9) e = 1'b1;
            acc = acc * 10 + d;
        end
        v = e ? 32'd0 : 32'(acc);
    endfunction

    task automatic run(input logic [4*NDIG-1:0] b, input string tag);
        logic [31:0] ev;
        logic        ee;
        int          n;
        int          busy_n;
        bit          got;
        model(b, ev, ee);
        @(negedge clk);
        bcd_in = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        bcd_in = 16'($urandom);
        n      = 0;
        busy_n = 0;
        got    = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (busy) busy_n++;
            if (valid) got = 1'b1;
        end
        chk({tag, "_valid_seen"}, 32'(got), 32'd1);
        chk({tag, "_latency"}, 32'(n), ee ? 32'd2 : 32'd18);
        chk({tag, "_bin_out"}, bin_out, ev);
        chk({tag, "_err"}, 32'(err), 32'(ee));
        chk({tag, "_busy_cycles"}, 32'(busy_n), ee ? 32'd2 : 32'd18);
        @(negedge clk);
        chk({tag, "_valid_width"}, 32'(valid), 32'd0);
        chk({tag, "_busy_drop"}, 32'(busy), 32'd0);
    endtask

    initial begin : main
        logic [31:0]       ev;
        logic              ee;
        logic [4*NDIG-1:0] rb;
        int                nv;
        int                last;
        int                w;
        logic [31:0]       seen;

        rst_n  = 1'b0;
        start  = 1'b0;
        bcd_in = '0;
        #3;
        chk("rst_bin_out", bin_out, 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run(16'h0000, "zero");
        run(16'h9999, "max");
        run(16'h1234, "d1234");
        run(16'h12A4, "bad12A4");
        run(16'h0007, "after_bad");

        // abort mid-conversion with an asynchronous reset
        @(negedge clk);
        bcd_in = 16'h1234;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_bin_out", bin_out, 32'd0);
        chk("abort_valid", 32'(valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (valid) nv++;
        end
        chk("abort_no_valid", 32'(nv), 32'd0);
        run(16'h0042, "post_abort");

        // start pulses while busy are ignored, bcd_in changes ignored
        @(negedge clk);
        bcd_in = 16'h0500;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        bcd_in = 16'h9999;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        nv   = 0;
        seen = 32'hFFFF_FFFF;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (valid) begin
                nv++;
                seen = bin_out;
            end
        end
        chk("busy_start_valid_count", 32'(nv), 32'd1);
        chk("busy_start_bin_out", seen, 32'd500);

        // start held high: back-to-back with one idle cycle between
        @(negedge clk);
        bcd_in = 16'h0010;
        start  = 1'b1;
        nv   = 0;
        last = 0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (valid) begin
                nv++;
                chk("held_bin_out", bin_out, 32'd10);
                chk("held_err", 32'(err), 32'd0);
                if (last != 0) chk("held_period", 32'(i - last), 32'd19);
                last = i;
            end
        end
        chk("held_valid_count", 32'(nv), 32'd4);
        start = 1'b0;
        w = 0;
        while ((busy || valid) && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("held_drain_idle", 32'(busy), 32'd0);

        // randomized digits, occasionally illegal
        for (int t = 0; t < 24; t++) begin
            rb = '0;
            for (int d = 0; d < NDIG; d++) begin
                if ($urandom_range(0, 7) == 0)
                    rb[4*d +: 4] = 4'($urandom_range(10, 15));
                else
                    rb[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            model(rb, ev, ee);
            run(rb, ee ? "rand_bad" : "rand_ok");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
